// File: rtl/sram_like_responder_pkg.sv
// ---------------------------------------------------------------------------
// sram_like_responder_pkg
// Shared constants for the sram-like responder: transfer size encodings,
// the LFSR feedback tap mask used by the random-delay build, and the helper
// that turns a size/byte-offset pair into a byte-lane mask.
// ---------------------------------------------------------------------------
package sram_like_responder_pkg;

    typedef enum logic [1:0] {
        SRAM_SIZE_BYTE = 2'd0,
        SRAM_SIZE_HALF = 2'd1,
        SRAM_SIZE_WORD = 2'd2,
        SRAM_SIZE_RSVD = 2'd3
    } sram_size_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Byte lanes touched by an access of the given size at the given offset.
    // Unaligned half/word offsets are deliberately not corrected; the
    // reserved size selects no lanes at all.
    function automatic logic [3:0] size_mask(input logic [1:0] size,
                                             input logic [1:0] lo);
        logic [3:0] mask;
        mask = 4'b0000;
        case (sram_size_e'(size))
            SRAM_SIZE_BYTE: mask = 4'b0001 << lo;
            SRAM_SIZE_HALF: mask = 4'b0011 << {lo[1], 1'b0};
            SRAM_SIZE_WORD: mask = 4'b1111;
            default:        mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sram_like_responder_if.sv
// ---------------------------------------------------------------------------
// sram_like_responder_if
// Request/addr_ok/data_ok bus between a CPU-side initiator (master) and the
// memory-side responder (slave).
//   req/wr/size/wstrb/addr/wdata : request fields, held until accepted
//   addr_ok                      : request accepted this cycle
//   data_ok/rdata                : in-order response pulse and its data
// ---------------------------------------------------------------------------
interface sram_like_responder_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_resp_fifo.sv
// ---------------------------------------------------------------------------
// sram_resp_fifo
// Small synchronous FIFO holding captured responses until they are handed
// back on data_ok.
//   clk, resetn : clock and asynchronous active-low reset
//   push, din   : write one entry
//   pop         : drop the head entry
//   dout        : current head entry (reads as 0 after reset)
//   empty       : no entries stored
// The owner guarantees no push when full and no pop when empty.
// ---------------------------------------------------------------------------
module sram_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Pointers wrap explicitly so a depth of 1 works with a 1-bit pointer.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/sram_like_responder.sv
// ---------------------------------------------------------------------------
// sram_like_responder
// Target side of the sram-like bus. Each accepted request is issued as one
// access to a synchronous single-port RAM (1-cycle read latency) in the
// accept cycle; the result is captured one cycle later and returned strictly
// in order through a response FIFO.
//   clk, resetn   : clock and asynchronous active-low reset
//   bus (slave)   : req/wr/size/wstrb/addr/wdata in, addr_ok/data_ok/rdata out
//   ram_en/ram_we : RAM access strobe and byte write enables
//   ram_addr      : RAM word address, addr[RAM_AW+1:2]
//   ram_wdata     : RAM write data
//   ram_rdata     : RAM read data, valid the cycle after a read strobe
// Build option: define RANDOM_DELAY_EN to insert pseudo-random accept and
// response stalls driven by a 16-bit LFSR seeded with LFSR_SEED.
// ---------------------------------------------------------------------------
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter int          RAM_AW    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  resetn,
    sram_like_responder_if.slave  bus,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          stall_a;
    logic          stall_d;
    logic          accept;
    logic          data_ok;
    logic [CW-1:0] cnt;
    logic          p_valid;
    logic          p_wr;
    logic [31:0]   fifo_din;
    logic [31:0]   fifo_dout;
    logic          fifo_empty;
    logic          unused_addr_bits;

`ifdef RANDOM_DELAY_EN
    logic [15:0] lfsr;

    // Free-running LFSR; each stall is the AND of two bits, so ~25% duty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign stall_a = lfsr[0] & lfsr[1];
    assign stall_d = lfsr[2] & lfsr[3];
`else
    localparam logic [15:0] unused_seed = LFSR_SEED;

    assign stall_a = 1'b0;
    assign stall_d = 1'b0;
`endif

    // addr_ok looks only at the registered count, so a slot freed by data_ok
    // becomes usable on the following cycle.
    assign bus.addr_ok = resetn && (cnt < DEPTH_C) && !stall_a;
    assign accept      = bus.req && bus.addr_ok;

    assign ram_en    = accept;
    assign ram_addr  = bus.addr[RAM_AW+1:2];
    assign ram_wdata = bus.wdata;
    assign ram_we    = bus.wr ? (bus.wstrb & size_mask(bus.size, bus.addr[1:0])) : 4'b0000;

    assign unused_addr_bits = ^bus.addr[31:RAM_AW+2];

    // Outstanding-request counter: up on accept, down on data_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            case ({accept, data_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Issue stage: remembers that the RAM was accessed last cycle and whether
    // that access was a write, so the read port is sampled at the right time.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_valid <= 1'b0;
            p_wr    <= 1'b0;
        end else begin
            p_valid <= accept;
            p_wr    <= bus.wr;
        end
    end

    // Write responses carry zero data; the RAM read port is ignored for them.
    assign fifo_din = p_wr ? 32'h0 : ram_rdata;

    sram_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_resp_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (p_valid),
        .pop    (data_ok),
        .din    (fifo_din),
        .dout   (fifo_dout),
        .empty  (fifo_empty)
    );

    assign data_ok     = !fifo_empty && !stall_d;
    assign bus.data_ok = data_ok;
    assign bus.rdata   = fifo_dout;

endmodule

// File: tb/tb_sram_like_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_like_responder
// Self-checking bench for sram_like_responder with a behavioural RAM and a
// reference memory/response-queue model of the bus behaviour.
// ---------------------------------------------------------------------------
module tb_sram_like_responder;

    localparam int DEPTH  = 2;
    localparam int RAM_AW = 16;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    sram_like_responder_if bus();

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    sram_like_responder #(
        .DEPTH     (DEPTH),
        .RAM_AW    (RAM_AW),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous single-port RAM with one-cycle read latency.
    bit [31:0] ram_mem [0:(1<<RAM_AW)-1];

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            if (ram_we == 4'b0000) ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Reference model state.
    typedef struct {
        int          ready;
        logic [31:0] data;
    } exp_t;

    bit [31:0]   ref_mem [0:(1<<RAM_AW)-1];
    exp_t        expq[$];
    int          resp_cyc[$];
    logic [31:0] resp_data[$];
    logic [3:0]  last_we;
    int          cyc    = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lanes written by a request, derived lane by lane from the size rules.
    function automatic logic [3:0] lanes(input logic w, input logic [1:0] sz,
                                         input logic [3:0] st, input logic [31:0] a);
        logic [3:0] m;
        m = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            case (sz)
                2'd0: m[b] = (b == int'(a[1:0]));
                2'd1: m[b] = ((b / 2) == int'(a[1]));
                2'd2: m[b] = 1'b1;
                default: m[b] = 1'b0;
            endcase
        end
        return w ? (m & st) : 4'b0000;
    endfunction

    // Monitor / compare process, sampling on the falling edge.
    initial begin
        logic        acc;
        logic        head_ready;
        logic [3:0]  m;
        logic [15:0] widx;
        exp_t        e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                checkOutput("rst_data_ok", bus.data_ok, 1'b0);
                checkOutput("rst_addr_ok", bus.addr_ok, 1'b0);
                checkOutput("rst_ram_en", ram_en, 1'b0);
                expq.delete();
            end else begin
                acc = bus.req && bus.addr_ok;
                checkOutput("ram_en", ram_en, acc);
                head_ready = (expq.size() > 0) && (expq[0].ready <= cyc);
`ifdef RANDOM_DELAY_EN
                if (bus.addr_ok) checkOutput("addr_ok_room", (expq.size() < DEPTH), 1'b1);
                if (bus.data_ok) checkOutput("data_ok_ready", head_ready, 1'b1);
`else
                checkOutput("addr_ok", bus.addr_ok, (expq.size() < DEPTH));
                checkOutput("data_ok", bus.data_ok, head_ready);
`endif
                if (bus.data_ok && expq.size() > 0) begin
                    checkOutput("rdata", bus.rdata, expq[0].data);
                    resp_cyc.push_back(cyc);
                    resp_data.push_back(bus.rdata);
                    void'(expq.pop_front());
                end
                if (acc) begin
                    widx = bus.addr[RAM_AW+1:2];
                    m = lanes(bus.wr, bus.size, bus.wstrb, bus.addr);
                    last_we = ram_we;
                    checkOutput("ram_we", ram_we, m);
                    checkOutput("ram_addr", ram_addr, widx);
                    checkOutput("ram_wdata", ram_wdata, bus.wdata);
                    e.ready = cyc + 2;
                    e.data  = bus.wr ? 32'h0 : ref_mem[widx];
                    expq.push_back(e);
                    for (int b = 0; b < 4; b++) begin
                        if (m[b]) ref_mem[widx][8*b +: 8] = bus.wdata[8*b +: 8];
                    end
                    checkOutput("outstanding", (expq.size() <= DEPTH), 1'b1);
                end
            end
        end
    end

    // Drive one request and wait (bounded) until it is accepted.
    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic [3:0] st,
                                 input logic [31:0] a, input logic [31:0] d, output int acc_cyc);
        bit done;
        @(posedge clk);
        #1;
        bus.req   = 1'b1;
        bus.wr    = w;
        bus.size  = sz;
        bus.wstrb = st;
        bus.addr  = a;
        bus.wdata = d;
        acc_cyc = -1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            #1;
            if (bus.req && bus.addr_ok) begin
                acc_cyc = cyc;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: no addr_ok within 50 cycles for addr %h", a);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic expectResp(input string name, input int c, input logic [31:0] d);
        bit found;
        found = 1'b0;
        foreach (resp_cyc[i]) begin
            if (resp_cyc[i] == c && !found) begin
                found = 1'b1;
                checkOutput(name, resp_data[i], d);
            end
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: no data_ok at cycle %0d, expected rdata %h", name, c, d);
        end
    endtask

    initial begin
        int a0, a1, a2;
        int acc[4];
        logic [31:0] pdata[4];
        bus.req   = 1'b1;
        bus.wr    = 1'b0;
        bus.size  = 2'd2;
        bus.wstrb = 4'hF;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        last_we   = 4'h0;
        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_data_ok", bus.data_ok, 1'b0);
        checkOutput("reset_rdata", bus.rdata, 32'h0);
        checkOutput("reset_addr_ok", bus.addr_ok, 1'b0);
        checkOutput("reset_ram_en", ram_en, 1'b0);
        bus.req = 1'b0;
        @(posedge clk);
        #3;
        resetn = 1'b1;

        $display("[TB] word write then read");
        applyStimulus(1'b1, 2'd2, 4'hF, 32'h100, 32'hDEADBEEF, a0);
        applyStimulus(1'b0, 2'd2, 4'hF, 32'h100, 32'h0, a1);
        idle(5);
        checkOutput("t1_back_to_back", a1 - a0, 1);
        expectResp("t1_write_resp", a0 + 2, 32'h0);
        expectResp("t1_read_resp", a0 + 3, 32'hDEADBEEF);

        $display("[TB] byte write masking");
        applyStimulus(1'b1, 2'd2, 4'hF, 32'h200, 32'h11223344, a0);
        applyStimulus(1'b1, 2'd0, 4'hF, 32'h202, 32'hAABBCCDD, a1);
        checkOutput("t2_ram_we", last_we, 4'b0100);
        applyStimulus(1'b0, 2'd2, 4'hF, 32'h200, 32'h0, a2);
        idle(5);
        expectResp("t2_read_resp", a2 + 2, 32'h11BB3344);

        $display("[TB] back-pressure");
        pdata[0] = 32'hA0A0_0001;
        pdata[1] = 32'hB1B1_0002;
        pdata[2] = 32'hC2C2_0003;
        pdata[3] = 32'hD3D3_0004;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd2, 4'hF, 32'h10 + 4*i, pdata[i], a0);
        idle(5);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'd2, 4'hF, 32'h10 + 4*i, 32'h0, acc[i]);
        idle(8);
        checkOutput("t3_third_accept_gap", acc[2] - acc[0], 3);
        checkOutput("t3_fourth_accept_gap", acc[3] - acc[0], 4);
        expectResp("t3_resp0", acc[0] + 2, pdata[0]);
        expectResp("t3_resp1", acc[0] + 3, pdata[1]);
        expectResp("t3_resp2", acc[0] + 5, pdata[2]);
        expectResp("t3_resp3", acc[0] + 6, pdata[3]);

        $display("[TB] reset mid-flight");
        applyStimulus(1'b0, 2'd2, 4'hF, 32'h100, 32'h0, a0);
        @(posedge clk);
        #1;
        bus.addr = 32'h104;
        #1;
        checkOutput("t4_ram_en_before", ram_en, 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("t4_data_ok_low", bus.data_ok, 1'b0);
        checkOutput("t4_addr_ok_low", bus.addr_ok, 1'b0);
        checkOutput("t4_ram_en_low", ram_en, 1'b0);
        bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        applyStimulus(1'b0, 2'd2, 4'hF, 32'h100, 32'h0, a1);
        idle(5);
        expectResp("t4_first_after_reset", a1 + 2, 32'hDEADBEEF);

        $display("[TB] reserved size write");
        applyStimulus(1'b1, 2'd2, 4'hF, 32'h300, 32'hCAFEF00D, a0);
        applyStimulus(1'b1, 2'd3, 4'hF, 32'h300, 32'h12345678, a1);
        checkOutput("t5_ram_we", last_we, 4'b0000);
        applyStimulus(1'b0, 2'd2, 4'hF, 32'h300, 32'h0, a2);
        idle(5);
        expectResp("t5_write_resp", a1 + 2, 32'h0);
        expectResp("t5_read_resp", a2 + 2, 32'hCAFEF00D);

        $display("[TB] random traffic");
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          4'($urandom), 32'h400 + $urandom_range(0, 255),
                          $urandom, a0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
        end
        idle(12);
        checkOutput("drain_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
